rv_multicycle_sequencer: RTL and testbench

Parametrised multicycle instruction sequencer for the RV32I core. It replaces the fixed 50M-cycle wait-count FSM with a programmable settle time per phase and a req/ack instruction-fetch handshake with timeout. It also adds run/halt control, error reporting and a retired-instruction counter. It sits between the instruction memory, the decoder/ALU datapath and the register file, owning `pc` and the phase strobes.

---
 rtl/rv_multicycle_sequencer.sv | 153 +++++++++++++++
 tb/tb_rv_multicycle_sequencer.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/rv_multicycle_sequencer.sv
// Multicycle instruction sequencer for the RV32I core: fetch handshake with timeout,
// programmable per-phase settle time, run/halt control. Optional STEP_MODE_EN adds single-step.
module rv_multicycle_sequencer #(
  parameter int unsigned      XLEN        = 32,
  parameter logic [XLEN-1:0]  RESET_PC    = '0,
  parameter int unsigned      WAIT_CYCLES = 0,
  parameter int unsigned      MEM_TIMEOUT = 255
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            run,
  output logic            mem_req,
  output logic [XLEN-1:0] mem_addr,
  input  logic            mem_ack,
  input  logic [31:0]     mem_rdata,
  output logic [31:0]     instr,
  input  logic            illegal,
  input  logic [1:0]      next_pc_sel,
  input  logic [XLEN-1:0] target,
  output logic            alu_en,
  output logic            reg_wren,
  output logic [XLEN-1:0] pc,
  output logic [2:0]      state,
  output logic            halted,
  output logic [1:0]      err_code,
  output logic [31:0]     retired
`ifdef STEP_MODE_EN
  ,
  input  logic            step
`endif
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_FETCH  = 3'd1;
  localparam logic [2:0] S_WAIT   = 3'd2;
  localparam logic [2:0] S_DECODE = 3'd3;
  localparam logic [2:0] S_EXEC   = 3'd4;
  localparam logic [2:0] S_WB     = 3'd5;
  localparam logic [2:0] S_HALT   = 3'd7;

  localparam int unsigned CNT_W = 16;
  localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(WAIT_CYCLES);
  localparam logic [CNT_W-1:0] TMO_LAST    = CNT_W'(MEM_TIMEOUT - 1);

  logic [CNT_W-1:0] cnt, cnt_d;
  logic [2:0]       state_d;
  logic             mem_req_d, alu_en_d, reg_wren_d, halted_d;
  logic [XLEN-1:0]  pc_d, pc_new;
  logic [31:0]      instr_d, retired_d;
  logic [1:0]       err_d;
  logic             settle_done, take_tgt, start;

  assign mem_addr = pc;

`ifdef STEP_MODE_EN
  assign start = run | step;
`else
  assign start = run;
`endif

  // Next-state and registered-output computation
  always_comb begin
    state_d     = state;
    mem_req_d   = 1'b0;
    alu_en_d    = 1'b0;
    reg_wren_d  = 1'b0;
    halted_d    = 1'b0;
    pc_d        = pc;
    instr_d     = instr;
    err_d       = err_code;
    retired_d   = retired;
    cnt_d       = '0;
    settle_done = (cnt == SETTLE_LAST);
    take_tgt    = (next_pc_sel == 2'b01) || (next_pc_sel == 2'b10);
    pc_new      = take_tgt ? target : pc + XLEN'(4);

    case (state)
      S_IDLE:   if (start) state_d = S_FETCH;
      S_FETCH:  state_d = S_WAIT;
      S_WAIT: begin
        if (mem_ack) begin
          instr_d = mem_rdata;
          state_d = S_DECODE;
        end else if (cnt == TMO_LAST) begin
          state_d = S_HALT;
          err_d   = 2'b10;
        end
      end
      S_DECODE: begin
        if (settle_done) begin
          if (illegal) begin
            state_d = S_HALT;
            err_d   = 2'b01;
          end else begin
            state_d = S_EXEC;
          end
        end
      end
      S_EXEC:   if (settle_done) state_d = S_WB;
      S_WB: begin
        if (settle_done) begin
          // Misaligned redirect faults before any architectural update
          if (take_tgt && (target[1:0] != 2'b00)) begin
            state_d = S_HALT;
            err_d   = 2'b11;
          end else begin
            reg_wren_d = 1'b1;
            pc_d       = pc_new;
            retired_d  = retired + 32'd1;
            state_d    = run ? S_FETCH : S_IDLE;
          end
        end
      end
      S_HALT:   state_d = S_HALT;
      default:  state_d = S_IDLE;
    endcase

    // Shared settle/timeout counter restarts on every state change
    if ((state_d == state) && (state != S_IDLE) && (state != S_HALT))
      cnt_d = cnt + CNT_W'(1);

    mem_req_d = (state_d == S_FETCH);
    alu_en_d  = (state_d == S_EXEC) && (cnt_d == SETTLE_LAST);
    halted_d  = (state_d == S_HALT);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= S_IDLE;
      cnt      <= '0;
      pc       <= RESET_PC;
      instr    <= '0;
      mem_req  <= 1'b0;
      alu_en   <= 1'b0;
      reg_wren <= 1'b0;
      halted   <= 1'b0;
      err_code <= 2'b00;
      retired  <= '0;
    end else begin
      state    <= state_d;
      cnt      <= cnt_d;
      pc       <= pc_d;
      instr    <= instr_d;
      mem_req  <= mem_req_d;
      alu_en   <= alu_en_d;
      reg_wren <= reg_wren_d;
      halted   <= halted_d;
      err_code <= err_d;
      retired  <= retired_d;
    end
  end

endmodule

// File: tb/tb_rv_multicycle_sequencer.sv
// Randomized self-checking bench for rv_multicycle_sequencer; the bench acts as instruction memory.
module tb_rv_multicycle_sequencer;

  localparam int unsigned W   = 2;
  localparam int unsigned T   = 4;
  localparam logic [31:0] RPC = 32'h0000_0100;

  logic        clk = 1'b0;
  logic        rst, run, mem_ack, illegal;
  logic [31:0] mem_rdata, target;
  logic [1:0]  next_pc_sel;
  logic        mem_req, alu_en, reg_wren, halted;
  logic [31:0] mem_addr, instr, pc, retired;
  logic [2:0]  state;
  logic [1:0]  err_code;
`ifdef STEP_MODE_EN
  logic        step;
`endif

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  logic [31:0] exp_pc, exp_ret;
  bit          exp_halted;
  int          exp_period, last_req_cyc;

  rv_multicycle_sequencer #(
    .XLEN(32), .RESET_PC(RPC), .WAIT_CYCLES(W), .MEM_TIMEOUT(T)
  ) dut (
    .clk(clk), .rst(rst), .run(run),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .instr(instr), .illegal(illegal), .next_pc_sel(next_pc_sel), .target(target),
    .alu_en(alu_en), .reg_wren(reg_wren), .pc(pc), .state(state),
    .halted(halted), .err_code(err_code), .retired(retired)
`ifdef STEP_MODE_EN
    , .step(step)
`endif
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0;
    #1;
    check_eq("rst_state", 32'(state), 32'd0);
    check_eq("rst_halted", 32'(halted), 32'd0);
    check_eq("rst_strobes", {29'd0, mem_req, alu_en, reg_wren}, 32'd0);
    run = 1'b0; mem_ack = 1'b0; illegal = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    exp_pc = RPC; exp_ret = '0; exp_halted = 1'b0; exp_period = 0;
  endtask

  // One instruction: k = ack delay after mem_req (0 = never ack)
  task automatic do_instr(input int k, input bit ill, input logic [1:0] sel,
                          input logic [31:0] tgt, input bit run_next, input bit mid_step);
    int n, t_end, alu_t, alu_n, wren_n;
    logic [31:0] word;
    bit mis, commit;
    n = 0;
    while (mem_req !== 1'b1 && n < 40) begin
      @(negedge clk);
      n++;
    end
    check_eq("req_seen", 32'(mem_req), 32'd1);
    if (mem_req !== 1'b1) begin
      exp_halted = 1'b1;
      return;
    end
    check_eq("mem_addr", mem_addr, exp_pc);
    if (exp_period != 0) check_eq("period", 32'(cyc - last_req_cyc), 32'(exp_period));
    last_req_cyc = cyc;
    exp_period   = 0;
    word         = $urandom;
    mem_rdata    = word;
    illegal      = ill;
    next_pc_sel  = sel;
    target       = tgt;
    run          = run_next;
    mem_ack      = (k != 1) ? 1'($urandom_range(0, 1)) : 1'b0;

    if (k == 0) begin
      for (int j = 1; j <= int'(T); j++) begin
        @(negedge clk);
        mem_ack = 1'b0;
        if (j == int'(T)) check_eq("tmo_still_wait", 32'(state), 32'd2);
      end
      @(negedge clk);
      check_eq("tmo_state", 32'(state), 32'd7);
      check_eq("tmo_halted", 32'(halted), 32'd1);
      check_eq("tmo_err", 32'(err_code), 32'd2);
      exp_halted = 1'b1;
      return;
    end

    for (int j = 1; j <= k; j++) begin
      @(negedge clk);
      mem_ack = (j == k);
    end

    t_end = 3 * (1 + int'(W)) + 1;
    alu_n = 0; wren_n = 0; alu_t = 0;
    for (int t = 1; t <= t_end; t++) begin
      @(negedge clk);
      mem_ack = 1'b0;
`ifdef STEP_MODE_EN
      step = mid_step && (t == 1);
`endif
      if (t == 1) check_eq("instr", instr, word);
      if (alu_en === 1'b1) begin alu_n++; alu_t = t; end
      if (reg_wren === 1'b1) wren_n++;
    end

    mis    = ((sel == 2'b01) || (sel == 2'b10)) && (tgt[1:0] != 2'b00);
    commit = !ill && !mis;
    check_eq("alu_pulses", 32'(alu_n), ill ? 32'd0 : 32'd1);
    if (!ill) check_eq("alu_pos", 32'(alu_t), 32'(2 * (1 + int'(W))));
    check_eq("wren_pulses", 32'(wren_n), commit ? 32'd1 : 32'd0);
    check_eq("wren_at_commit", 32'(reg_wren), commit ? 32'd1 : 32'd0);
    if (commit) begin
      exp_pc  = ((sel == 2'b01) || (sel == 2'b10)) ? tgt : exp_pc + 32'd4;
      exp_ret = exp_ret + 32'd1;
      check_eq("next_state", 32'(state), run_next ? 32'd1 : 32'd0);
      check_eq("next_req", 32'(mem_req), 32'(run_next));
      if (run_next) exp_period = 1 + k + 3 * (1 + int'(W));
    end else begin
      check_eq("halt_state", 32'(state), 32'd7);
      check_eq("halt_flag", 32'(halted), 32'd1);
      check_eq("halt_err", 32'(err_code), ill ? 32'd1 : 32'd3);
      exp_halted = 1'b1;
    end
    check_eq("pc", pc, exp_pc);
    check_eq("retired", retired, exp_ret);
  endtask

  initial begin
    int req_cnt;
    rst = 1'b0; run = 1'b0; mem_ack = 1'b0; illegal = 1'b0;
    mem_rdata = '0; target = '0; next_pc_sel = 2'b00;
`ifdef STEP_MODE_EN
    step = 1'b0;
`endif
    exp_pc = RPC; exp_ret = '0; exp_halted = 1'b0; exp_period = 0; last_req_cyc = 0;
    repeat (2) @(negedge clk);
    check_eq("reset_state", 32'(state), 32'd0);
    check_eq("reset_pc", pc, RPC);
    check_eq("reset_instr", instr, 32'd0);
    check_eq("reset_strobes", {29'd0, mem_req, alu_en, reg_wren}, 32'd0);
    check_eq("reset_err", {29'd0, halted, err_code}, 32'd0);
    check_eq("reset_retired", retired, 32'd0);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check_eq("idle_no_run", {28'd0, mem_req, state}, 32'd0);

    // Sequential fetches, then ack after 3 cycles
    run = 1'b1;
    for (int i = 0; i < 3; i++) do_instr(1, 1'b0, 2'b00, 32'h0, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) do_instr(3, 1'b0, 2'b00, 32'h0, 1'b1, 1'b0);
    // Jump, then misaligned jump
    do_instr(1, 1'b0, 2'b10, 32'h0000_0200, 1'b1, 1'b0);
    do_instr(2, 1'b0, 2'b01, 32'h0000_0202, 1'b1, 1'b0);
    do_reset();
    run = 1'b1;
    do_instr(1, 1'b1, 2'b00, 32'h0, 1'b1, 1'b0);
    do_reset();
    run = 1'b1;
    do_instr(0, 1'b0, 2'b00, 32'h0, 1'b1, 1'b0);
    do_reset();
    // run dropped mid-instruction completes it, then resumes
    run = 1'b1;
    do_instr(T, 1'b0, 2'b11, 32'h0000_0ABC, 1'b0, 1'b0);
    run = 1'b1;
    do_instr(1, 1'b0, 2'b00, 32'h0, 1'b1, 1'b0);

    for (int i = 0; i < 40; i++) begin
      int k;
      bit ill, rn;
      logic [1:0] sel;
      logic [31:0] tgt;
      k   = ($urandom_range(0, 19) == 0) ? 0 : int'($urandom_range(1, T));
      ill = ($urandom_range(0, 15) == 0);
      sel = 2'($urandom);
      tgt = $urandom;
      if ($urandom_range(0, 7) != 0) tgt[1:0] = 2'b00;
      rn  = ($urandom_range(0, 3) != 0);
      run = 1'b1;
      do_instr(k, ill, sel, tgt, rn, 1'b0);
      if (exp_halted) do_reset();
    end

`ifdef STEP_MODE_EN
    do_reset();
    repeat (2) @(negedge clk);
    step = 1'b1;
    @(negedge clk);
    step = 1'b0;
    do_instr(1, 1'b0, 2'b00, 32'h0, 1'b0, 1'b1);
    check_eq("step_retired", retired, 32'd1);
    req_cnt = 0;
    repeat (8) begin
      @(negedge clk);
      if (mem_req === 1'b1) req_cnt++;
    end
    check_eq("step_no_more_req", 32'(req_cnt), 32'd0);
    check_eq("step_idle", 32'(state), 32'd0);
`endif

    // Reset mid-instruction aborts it with no strobes
    do_reset();
    run = 1'b1;
    do_instr(1, 1'b0, 2'b00, 32'h0, 1'b1, 1'b0);
    mem_ack = 1'b0;
    @(negedge clk);
    mem_ack = 1'b1;
    repeat (5) begin
      @(negedge clk);
      mem_ack = 1'b0;
    end
    rst = 1'b0;
    req_cnt = 0;
    repeat (4) begin
      @(negedge clk);
      if ((alu_en | reg_wren | mem_req) === 1'b1) req_cnt++;
    end
    check_eq("abort_strobes", 32'(req_cnt), 32'd0);
    rst = 1'b1;
    check_eq("abort_pc", pc, RPC);
    check_eq("abort_retired", retired, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
